// File: rtl/pe_nic_pkg.sv
// rtl/pe_nic_pkg.sv - NIC register map, agent FSM encoding and tx packet layout.
package pe_nic_pkg;

  localparam logic [1:0] ADDR_IN_BUF   = 2'b00;
  localparam logic [1:0] ADDR_IN_STAT  = 2'b01;
  localparam logic [1:0] ADDR_OUT_BUF  = 2'b10;
  localparam logic [1:0] ADDR_OUT_STAT = 2'b11;

  localparam int HDR_LSB = 32;
  localparam int SRC_LSB = 24;
  localparam int SEQ_W   = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_POLL_IN,
    ST_READ_IN,
    ST_POLL_OUT,
    ST_WRITE_OUT,
    ST_DONE
  } state_t;

  function automatic logic [63:0] make_tx_pkt(input logic [31:0] hdr,
                                              input logic [7:0]  src,
                                              input logic [15:0] seq);
    logic [63:0] p;
    p = '0;
    p[HDR_LSB +: 32]  = hdr;
    p[SRC_LSB +: 8]   = src;
    p[0 +: SEQ_W]     = seq;
    return p;
  endfunction

  function automatic logic [1:0] addr_of(input state_t s);
    case (s)
      ST_POLL_IN:   return ADDR_IN_STAT;
      ST_READ_IN:   return ADDR_IN_BUF;
      ST_POLL_OUT:  return ADDR_OUT_STAT;
      ST_WRITE_OUT: return ADDR_OUT_BUF;
      default:      return ADDR_IN_BUF;
    endcase
  endfunction

endpackage

// File: rtl/pe_nic_watchdog.sv
// rtl/pe_nic_watchdog.sv - no-progress cycle counter; expires at TIMEOUT-1 while running.
module pe_nic_watchdog #(
  parameter int TIMEOUT = 4096
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic run,
  output logic expire
);

  localparam int W = $clog2(TIMEOUT + 1);

  logic [W-1:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (run && !expire) begin
      count <= count + W'(1);
    end
  end

  assign expire = run && (count == W'(TIMEOUT - 1));

endmodule

// File: rtl/pe_nic_agent.sv
// rtl/pe_nic_agent.sv - PE stand-in that sends a packet burst to its NIC and drains arrivals.
module pe_nic_agent
  import pe_nic_pkg::*;
#(
  parameter int PACKET_WIDTH = 64,
  parameter int CNT_W        = 16,
  parameter int TIMEOUT      = 4096
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [7:0]              src_id,
  input  logic [31:0]             hdr,
  input  logic [CNT_W-1:0]        num_pkts,
  input  logic [CNT_W-1:0]        exp_rx,
  output logic [1:0]              addr,
  output logic [PACKET_WIDTH-1:0] d_out,
  input  logic [PACKET_WIDTH-1:0] d_in,
  output logic                    nicEn,
  output logic                    nicEnWR,
  output logic                    busy,
  output logic                    done,
  output logic                    timeout,
  output logic [CNT_W-1:0]        tx_count,
  output logic [CNT_W-1:0]        rx_count,
  output logic [PACKET_WIDTH-1:0] rx_last
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t state, next_state;
  logic   active, next_active;
  logic   tx_pending, rx_met, rx_met_after_read;
  logic   wd_clear, wd_expire;

  assign active            = (state != ST_IDLE) && (state != ST_DONE);
  assign next_active       = (next_state != ST_IDLE) && (next_state != ST_DONE);
  assign tx_pending        = tx_count < num_pkts;
  assign rx_met            = rx_count >= exp_rx;
  assign rx_met_after_read = ({1'b0, rx_count} + (CNT_W + 1)'(1)) >= {1'b0, exp_rx};
  assign wd_clear          = !active || (state == ST_READ_IN) || (state == ST_WRITE_OUT);

  pe_nic_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk    (clk),
    .reset  (reset),
    .clear  (wd_clear),
    .run    (active),
    .expire (wd_expire)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= next_state;
  end

  // Receive side is always checked first so a full input buffer is never starved.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE, ST_DONE: if (start) next_state = ST_POLL_IN;
      ST_POLL_IN: begin
        if (d_in[0])         next_state = ST_READ_IN;
        else if (tx_pending) next_state = ST_POLL_OUT;
        else if (rx_met)     next_state = ST_DONE;
      end
      ST_READ_IN: begin
        if (tx_pending)             next_state = ST_POLL_OUT;
        else if (rx_met_after_read) next_state = ST_DONE;
        else                        next_state = ST_POLL_IN;
      end
      ST_POLL_OUT:  next_state = d_in[0] ? ST_POLL_IN : ST_WRITE_OUT;
      ST_WRITE_OUT: next_state = ST_POLL_IN;
      default:      next_state = ST_IDLE;
    endcase
    if (active && wd_expire) next_state = ST_DONE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr     <= '0;
      d_out    <= '0;
      nicEn    <= 1'b0;
      nicEnWR  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      timeout  <= 1'b0;
      tx_count <= '0;
      rx_count <= '0;
      rx_last  <= '0;
    end else begin
      addr    <= addr_of(next_state);
      nicEn   <= next_active;
      nicEnWR <= (next_state == ST_WRITE_OUT);
      busy    <= next_active;
      if (next_state == ST_WRITE_OUT)
        d_out <= PACKET_WIDTH'(make_tx_pkt(hdr, src_id, 16'(tx_count)));
      if (!active && start) begin
        tx_count <= '0;
        rx_count <= '0;
        done     <= 1'b0;
        timeout  <= 1'b0;
      end
      if (state == ST_READ_IN) begin
        rx_last <= d_in;
        if (rx_count != CNT_MAX) rx_count <= rx_count + CNT_W'(1);
      end
      if (state == ST_WRITE_OUT && tx_count != CNT_MAX)
        tx_count <= tx_count + CNT_W'(1);
      if (active && next_state == ST_DONE) begin
        done    <= 1'b1;
        timeout <= wd_expire;
      end
    end
  end

endmodule

// File: tb/tb_pe_nic_agent.sv
// tb/tb_pe_nic_agent.sv - NIC BFM bench for pe_nic_agent with a tx-packet scoreboard.
module tb_pe_nic_agent;

  localparam int CW = 16;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [7:0]    src_id;
  logic [31:0]   hdr;
  logic [CW-1:0] num_pkts, exp_rx;
  logic [1:0]    addr;
  logic [63:0]   d_out, d_in;
  logic          nicEn, nicEnWR, busy, done, timeout;
  logic [CW-1:0] tx_count, rx_count;
  logic [63:0]   rx_last;

  logic          in_full, out_full;
  logic [63:0]   in_data;

  assign d_in = (addr == 2'b01) ? {63'd0, in_full}  :
                (addr == 2'b11) ? {63'd0, out_full} :
                (addr == 2'b00) ? in_data : 64'd0;

  pe_nic_agent #(.PACKET_WIDTH(64), .CNT_W(CW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .start(start), .src_id(src_id), .hdr(hdr),
    .num_pkts(num_pkts), .exp_rx(exp_rx), .addr(addr), .d_out(d_out), .d_in(d_in),
    .nicEn(nicEn), .nicEnWR(nicEnWR), .busy(busy), .done(done), .timeout(timeout),
    .tx_count(tx_count), .rx_count(rx_count), .rx_last(rx_last)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [CW-1:0] num;
    logic [CW-1:0] exp;
    logic [7:0]    src;
    logic [31:0]   hdr;
    logic          inj;
    logic [63:0]   data;
    logic [CW-1:0] etx;
    logic [CW-1:0] erx;
    logic          eto;
  } vec_t;

  int          tests = 0;
  int          fails = 0;
  int          wr_count;
  logic [63:0] exp_q[$];
  logic [2:0]  trace[$];
  vec_t        vecs[5];
  vec_t        v;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  // One cycle of the NIC model: observe the access issued this cycle.
  task automatic step();
    @(negedge clk);
    if (nicEn) begin
      trace.push_back({nicEnWR, addr});
      if (nicEnWR) begin
        wr_count++;
        check("wr_addr", 64'(addr), 64'd2);
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL wr_unexpected: got %h want none", d_out);
        end else begin
          check("wr_pkt", d_out, exp_q.pop_front());
        end
      end else if (addr == 2'b00) begin
        in_full = 1'b0;
      end
    end
  endtask

  task automatic setup_case(input vec_t c);
    trace.delete();
    exp_q.delete();
    wr_count = 0;
    num_pkts = c.num;
    exp_rx   = c.exp;
    src_id   = c.src;
    hdr      = c.hdr;
    if (c.inj) begin
      in_data = c.data;
      in_full = 1'b1;
    end
    for (int s = 0; s < int'(c.num); s++)
      exp_q.push_back({c.hdr, c.src, 8'h00, 16'(s)});
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic finish_case(input string name, input vec_t c);
    for (int i = 0; i < 300 && !done; i++) step();
    check({name, "_done"}, 64'(done), 64'd1);
    check({name, "_timeout"}, 64'(timeout), 64'(c.eto));
    check({name, "_tx_count"}, 64'(tx_count), 64'(c.etx));
    check({name, "_rx_count"}, 64'(rx_count), 64'(c.erx));
    if (c.inj) check({name, "_rx_last"}, rx_last, c.data);
    check({name, "_sb_left"}, 64'(exp_q.size()), 64'd0);
    check({name, "_idle_nicEn"}, {62'd0, nicEn, busy}, 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_bound: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int ri, wi;
    vecs[0] = '{16'd3, 16'd0, 8'h05, 32'hA012_0000, 1'b0, 64'd0, 16'd3, 16'd0, 1'b0};
    vecs[1] = '{16'd0, 16'd1, 8'h05, 32'h0000_0000, 1'b1, 64'hDEAD_BEEF_0000_0001, 16'd0, 16'd1, 1'b0};
    vecs[2] = '{16'd2, 16'd0, 8'hA3, 32'h4035_0000, 1'b0, 64'd0, 16'd2, 16'd0, 1'b0};
    vecs[3] = '{16'd0, 16'd0, 8'h11, 32'h2000_0000, 1'b0, 64'd0, 16'd0, 16'd0, 1'b0};
    vecs[4] = '{16'd2, 16'd1, 8'h7F, 32'hE0FF_0000, 1'b1, 64'h0123_4567_89AB_CDEF, 16'd2, 16'd1, 1'b0};

    reset = 1'b1; start = 1'b0; src_id = '0; hdr = '0; num_pkts = '0; exp_rx = '0;
    in_full = 1'b0; out_full = 1'b0; in_data = '0; wr_count = 0;
    repeat (3) @(negedge clk);
    check("rst_strobes", {59'd0, addr, nicEn, nicEnWR, busy}, 64'd0);
    check("rst_flags", {62'd0, done, timeout}, 64'd0);
    check("rst_counts", {32'd0, tx_count, rx_count}, 64'd0);
    check("rst_data", d_out | rx_last, 64'd0);
    reset = 1'b0;

    for (int k = 0; k < 5; k++) begin
      setup_case(vecs[k]);
      finish_case($sformatf("vec%0d", k), vecs[k]);
    end

    // Arriving packet: status read then buffer read back to back.
    setup_case(vecs[1]);
    finish_case("rx_seq", vecs[1]);
    check("rx_seq_len", 64'(trace.size()), 64'd2);
    if (trace.size() >= 2) begin
      check("rx_seq_0", 64'(trace[0]), 64'(3'b001));
      check("rx_seq_1", 64'(trace[1]), 64'(3'b000));
    end

    // Output buffer held full: polls alternate, no write until it clears.
    v = '{16'd1, 16'd0, 8'h05, 32'hA012_0000, 1'b0, 64'd0, 16'd1, 16'd0, 1'b0};
    out_full = 1'b1;
    setup_case(v);
    repeat (9) step();
    check("ofull_len", 64'(trace.size()), 64'd10);
    for (int j = 0; j < trace.size(); j++)
      check($sformatf("ofull_poll%0d", j), 64'(trace[j]), (j % 2 == 0) ? 64'd1 : 64'd3);
    out_full = 1'b0;
    finish_case("ofull", v);
    check("ofull_writes", 64'(wr_count), 64'd1);

    // Input full with tx pending: read is served before the write.
    v = '{16'd1, 16'd1, 8'h05, 32'hA012_0000, 1'b1, 64'h5555_AAAA_1234_0009, 16'd1, 16'd1, 1'b0};
    setup_case(v);
    finish_case("order", v);
    ri = -1; wi = -1;
    for (int j = 0; j < trace.size(); j++) begin
      if (trace[j] == 3'b000 && ri < 0) ri = j;
      if (trace[j] == 3'b110 && wi < 0) wi = j;
    end
    check("order_rd_before_wr", 64'((ri >= 0) && (wi > ri)), 64'd1);

    // Watchdog: nothing arrives, done/timeout appear exactly TO cycles after start.
    v = '{16'd0, 16'd1, 8'h05, 32'h0, 1'b0, 64'd0, 16'd0, 16'd0, 1'b1};
    setup_case(v);
    repeat (TO - 1) step();
    check("wd_before", {62'd0, done, nicEn}, 64'd1);
    step();
    check("wd_at", {61'd0, done, timeout, nicEn}, 64'b110);
    repeat (3) step();
    finish_case("wd", v);

    // Reset during the second write abandons it and clears the counters.
    setup_case(vecs[0]);
    for (int i = 0; i < 60 && wr_count < 2; i++) step();
    check("rst_mid_reached", 64'(wr_count), 64'd2);
    reset = 1'b1;
    #1;
    check("rst_mid_nicEn", 64'(nicEn), 64'd0);
    check("rst_mid_state", {46'd0, busy, done, tx_count}, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    setup_case(vecs[2]);
    finish_case("after_rst", vecs[2]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
